soc_evt_collector: RTL and testbench
====================================

Name: soc_evt_collector

Overview:
- Sits directly upstream of the cluster event unit's SoC-peripheral event FIFO port.
- Collects single-cycle event pulses from NB_EVT_LINES SoC peripheral lines and counts pending occurrences per line.
- Serialises pending occurrences through a round-robin arbiter onto one valid/ready/data stream of event IDs.
- Drives the event unit's soc_periph_evt_valid_i / soc_periph_evt_data_i and consumes its soc_periph_evt_ready_o.

Parameters:
- NB_EVT_LINES, 32, number of incoming event pulse lines (1..256).
- EVNT_WIDTH, 8, width of the emitted event ID.
- PEND_CNT_W, 2, width of the per-line pending counter; a line saturates at 2^PEND_CNT_W-1.
- EVT_ID_OFFSET, 0, added to the line index to form the emitted ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- evt_i  in  NB_EVT_LINES  event pulses; each high cycle is one occurrence.
- evt_valid_o  out  1  output event valid.
- evt_ready_i  in  1  downstream ready; this is the FIFO not-full signal.
- evt_data_o  out  EVNT_WIDTH  event ID.
- evt_lost_o  out  NB_EVT_LINES  one-cycle pulse per occurrence dropped on saturation.
- busy_o  out  1  high when any counter is nonzero or evt_valid_o is high.

Behaviour:
- Reset: all pending counters = 0, RR pointer = 0, evt_valid_o = 0, evt_data_o = 0, evt_lost_o = 0, busy_o = 0. Reset mid-transfer drops everything; nothing is replayed.
- Counter k, next value:
  - increment only: +1 if evt_i[k] is high and no grant to k; at saturation it holds and evt_lost_o[k] pulses in the same cycle as the registered drop (registered output, visible next cycle).
  - decrement only: -1 if k is granted and evt_i[k] is low.
  - simultaneous increment and grant: count unchanged, no loss, even when saturated.
- Output register load enable = !evt_valid_o || evt_ready_i.
- Arbiter:
  - When load is enabled, a combinational round-robin arbiter picks the first k with count > 0, searching from (last_grant+1) mod NB_EVT_LINES with wrap-around.
  - On grant: evt_valid_o <= 1, evt_data_o <= EVT_ID_OFFSET + k (truncated to EVNT_WIDTH), last_grant <= k.
  - When load is enabled and nothing is pending: evt_valid_o <= 0 and evt_data_o holds.
- Handshake: a transfer occurs when evt_valid_o && evt_ready_i. While valid && !ready, evt_data_o and evt_valid_o stay stable. valid never drops without a transfer.
- Latency and throughput:
  - A pulse in cycle t gives count = 1 in t+1 and evt_valid_o in t+2 if idle.
  - Throughput is 1 event per cycle with ready held high.
- The arbiter sees only registered counts, never evt_i directly (no combinational path from evt_i to the outputs).
- Elaboration check: EVT_ID_OFFSET + NB_EVT_LINES <= 2^EVNT_WIDTH; otherwise $fatal.

Optional Feature:
- Macro SOC_EVT_LOST_CNT_EN.
- When defined:
  - Adds ports lost_cnt_o (out, 16) and lost_cnt_clr_i (in, 1).
  - lost_cnt_o counts the number of set evt_lost_o bits per cycle, saturating at 16'hFFFF; reset value 0.
  - lost_cnt_clr_i clears the counter. A clear in the same cycle as a loss yields that cycle's loss count, not 0.
- When undefined: the ports are absent and there is no counter logic. Core behaviour is identical either way.

Decomposition:
- Package soc_evt_pkg holds:
  - the event-ID typedef sized by EVNT_WIDTH default;
  - the lost-counter width constant (16);
  - a function computing a saturating increment.
- One sub-module, soc_evt_rr_arb: parameter N; inputs req[N] and last_grant index; outputs gnt_valid and gnt_idx. Purely combinational, instantiated once.

Test Plan:
- Single pulse on evt_i[5], ready=1 -> evt_valid_o high exactly at t+2 with evt_data_o=5 for one cycle; busy_o then returns to 0.
- evt_i[3] and evt_i[3+1]=evt_i[4] and evt_i[10] pulse together, ready=1 -> IDs 3, 4, 10 on consecutive cycles.
- Follow-up to the previous scenario: pulse 3 and 4 again -> the order continues RR: 3, 4 (pointer wraps past 10).
- ready=0, 5 pulses on line 2 with PEND_CNT_W=2 -> first loaded into the output, counter reaches 3, fifth pulse gives evt_lost_o[2]=1; ID 2 held stable; after ready=1 exactly 4 transfers of ID 2.
- Line 7 saturated (count 3) while being granted and pulsed in the same cycle -> count stays 3, evt_lost_o stays 0.
- Reset asserted while valid=1 and counts nonzero -> all outputs 0 immediately (asynchronous); after release, no events emitted.
- With SOC_EVT_LOST_CNT_EN: lines 0 and 1 lose in the same cycle -> lost_cnt_o += 2; lost_cnt_clr_i in the same cycle as one loss -> lost_cnt_o = 1.

Source files
------------

// File: rtl/soc_evt_pkg.sv
// Shared types and helpers for the SoC event collector.
// The lost-event counter (SOC_EVT_LOST_CNT_EN builds only) uses LOST_CNT_W and sat_add.
package soc_evt_pkg;

    localparam int EVNT_WIDTH_DEF = 8;
    localparam int LOST_CNT_W     = 16;

    typedef logic [EVNT_WIDTH_DEF-1:0] evt_id_t;

    function automatic logic [LOST_CNT_W-1:0] sat_add(
        input logic [LOST_CNT_W-1:0] a,
        input logic [LOST_CNT_W-1:0] b
    );
        logic [LOST_CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LOST_CNT_W] ? {LOST_CNT_W{1'b1}} : s[LOST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Combinational round-robin picker: first requester after last_grant_i, wrapping.
// last_grant_i itself is the lowest-priority candidate.
module soc_evt_rr_arb #(
    parameter int N     = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    int               pos;
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        pos         = 0;
        idx         = '0;
        for (int i = N; i >= 1; i--) begin
            pos = (int'(last_grant_i) + i) % N;
            idx = IDX_W'(pos);
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/soc_evt_collector.sv
// Counts SoC event pulses per line and serialises them as event IDs onto a valid/ready stream.
// Optional SOC_EVT_LOST_CNT_EN adds a saturating count of dropped occurrences.
module soc_evt_collector
    import soc_evt_pkg::*;
#(
    parameter int NB_EVT_LINES  = 32,
    parameter int EVNT_WIDTH    = 8,
    parameter int PEND_CNT_W    = 2,
    parameter int EVT_ID_OFFSET = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NB_EVT_LINES-1:0] evt_i,
    output logic                    evt_valid_o,
    input  logic                    evt_ready_i,
    output logic [EVNT_WIDTH-1:0]   evt_data_o,
    output logic [NB_EVT_LINES-1:0] evt_lost_o,
`ifdef SOC_EVT_LOST_CNT_EN
    output logic [LOST_CNT_W-1:0]   lost_cnt_o,
    input  logic                    lost_cnt_clr_i,
`endif
    output logic                    busy_o
);

    localparam int IDX_W = (NB_EVT_LINES > 1) ? $clog2(NB_EVT_LINES) : 1;
    localparam logic [PEND_CNT_W-1:0] CNT_MAX = '1;

    if (longint'(EVT_ID_OFFSET) + longint'(NB_EVT_LINES) > (longint'(1) << EVNT_WIDTH)) begin : g_bad_cfg
        $fatal(1, "soc_evt_collector: EVT_ID_OFFSET + NB_EVT_LINES exceeds EVNT_WIDTH id space");
    end

    logic [NB_EVT_LINES-1:0][PEND_CNT_W-1:0] cnt_q, cnt_d;
    logic [NB_EVT_LINES-1:0] lost_q, lost_d;
    logic [NB_EVT_LINES-1:0] req, gnt_vec;
    logic                    valid_q;
    logic [EVNT_WIDTH-1:0]   data_q;
    logic [IDX_W-1:0]        last_q;
    logic                    gnt_valid;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    load_en;

    assign load_en = !valid_q || evt_ready_i;

    soc_evt_rr_arb #(.N(NB_EVT_LINES), .IDX_W(IDX_W)) u_arb (
        .req_i        (req),
        .last_grant_i (last_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    // A pulse and a grant on the same line cancel out, even at saturation.
    always_comb begin
        cnt_d   = cnt_q;
        lost_d  = '0;
        req     = '0;
        gnt_vec = '0;
        for (int k = 0; k < NB_EVT_LINES; k++) begin
            req[k]     = |cnt_q[k];
            gnt_vec[k] = load_en && gnt_valid && (gnt_idx == IDX_W'(k));
            if (evt_i[k] && !gnt_vec[k]) begin
                if (cnt_q[k] == CNT_MAX) lost_d[k] = 1'b1;
                else                     cnt_d[k]  = cnt_q[k] + 1'b1;
            end else if (gnt_vec[k] && !evt_i[k]) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            lost_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            lost_q <= lost_d;
            if (load_en) begin
                if (gnt_valid) begin
                    valid_q <= 1'b1;
                    data_q  <= EVNT_WIDTH'(EVT_ID_OFFSET + int'(gnt_idx));
                    last_q  <= gnt_idx;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_data_o  = data_q;
    assign evt_lost_o  = lost_q;
    assign busy_o      = valid_q || (|req);

`ifdef SOC_EVT_LOST_CNT_EN
    logic [LOST_CNT_W-1:0] lost_pop, lost_cnt_q, lost_cnt_d;

    // Clear restarts from this cycle's losses so none slip through uncounted.
    always_comb begin
        lost_pop = '0;
        for (int k = 0; k < NB_EVT_LINES; k++) begin
            lost_pop = lost_pop + LOST_CNT_W'(lost_q[k]);
        end
        lost_cnt_d = lost_cnt_clr_i ? lost_pop : sat_add(lost_cnt_q, lost_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lost_cnt_q <= '0;
        else         lost_cnt_q <= lost_cnt_d;
    end

    assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_soc_evt_collector.sv
// Directed bench for soc_evt_collector: vector table plus hand-written corner sequences.
// Lost-counter checks are compiled in only with SOC_EVT_LOST_CNT_EN.
module tb_soc_evt_collector;
    import soc_evt_pkg::*;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] evt = '0;
    logic          rdy = 1'b0;
    logic          vld;
    logic [7:0]    data;
    logic [NB-1:0] lost;
    logic          busy;
`ifdef SOC_EVT_LOST_CNT_EN
    logic [LOST_CNT_W-1:0] lost_cnt;
    logic                  lost_clr = 1'b0;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    soc_evt_collector #(
        .NB_EVT_LINES(NB), .EVNT_WIDTH(8), .PEND_CNT_W(2), .EVT_ID_OFFSET(0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .evt_i       (evt),
        .evt_valid_o (vld),
        .evt_ready_i (rdy),
        .evt_data_o  (data),
        .evt_lost_o  (lost),
`ifdef SOC_EVT_LOST_CNT_EN
        .lost_cnt_o     (lost_cnt),
        .lost_cnt_clr_i (lost_clr),
`endif
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one cycle, then sample just after the closing edge.
    task automatic step(input logic [NB-1:0] e, input logic r);
        evt = e;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        evt   = '0;
        rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NB-1:0] evt;
        logic          rdy;
        logic          vld;
        evt_id_t       data;
        logic          busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int xfers;
        logic stable;

        // Three-line burst from reset, RR follow-up, then a lone pulse on line 5.
        tbl[0]  = '{(32'd1 << 3) | (32'd1 << 4) | (32'd1 << 10), 1'b1, 1'b0, 8'd0,  1'b1};
        tbl[1]  = '{32'd0, 1'b1, 1'b1, 8'd3,  1'b1};
        tbl[2]  = '{32'd0, 1'b1, 1'b1, 8'd4,  1'b1};
        tbl[3]  = '{32'd0, 1'b1, 1'b1, 8'd10, 1'b1};
        tbl[4]  = '{32'd0, 1'b1, 1'b0, 8'd10, 1'b0};
        tbl[5]  = '{(32'd1 << 3) | (32'd1 << 4), 1'b1, 1'b0, 8'd10, 1'b1};
        tbl[6]  = '{32'd0, 1'b1, 1'b1, 8'd3,  1'b1};
        tbl[7]  = '{32'd0, 1'b1, 1'b1, 8'd4,  1'b1};
        tbl[8]  = '{32'd0, 1'b1, 1'b0, 8'd4,  1'b0};
        tbl[9]  = '{32'd1 << 5, 1'b1, 1'b0, 8'd4, 1'b1};
        tbl[10] = '{32'd0, 1'b1, 1'b1, 8'd5,  1'b1};
        tbl[11] = '{32'd0, 1'b1, 1'b0, 8'd5,  1'b0};

        do_reset();
        chk("reset_valid", 32'(vld),  32'd0);
        chk("reset_data",  32'(data), 32'd0);
        chk("reset_lost",  lost,      32'd0);
        chk("reset_busy",  32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].evt, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), 32'(vld),  32'(tbl[i].vld));
            chk($sformatf("vec%0d_data", i),  32'(data), 32'(tbl[i].data));
            chk($sformatf("vec%0d_busy", i),  32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_lost", i),  lost,      32'd0);
        end

        // Saturation on line 2 with the sink stalled.
        step(32'd1 << 2, 1'b0);
        chk("sat_first_valid", 32'(vld), 32'd0);
        step(32'd1 << 2, 1'b0);
        chk("sat_loaded_valid", 32'(vld), 32'd1);
        chk("sat_loaded_data", 32'(data), 32'd2);
        step(32'd1 << 2, 1'b0);
        step(32'd1 << 2, 1'b0);
        chk("sat_no_loss_yet", lost, 32'd0);
        step(32'd1 << 2, 1'b0);
        chk("sat_loss_pulse", lost, 32'd1 << 2);
        step(32'd0, 1'b0);
        chk("sat_loss_clears", lost, 32'd0);
        chk("sat_hold_valid", 32'(vld), 32'd1);
        chk("sat_hold_data", 32'(data), 32'd2);
        xfers = 0;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (vld) begin
                xfers++;
                if (data !== 8'd2) stable = 1'b0;
            end
            step(32'd0, 1'b1);
        end
        chk("sat_drain_count", 32'(xfers), 32'd4);
        chk("sat_drain_id", 32'(stable), 32'd1);

        // Line 7 saturated, then granted and pulsed together: no loss, count kept.
        step(32'd1 << 7, 1'b0);
        step(32'd1 << 7, 1'b0);
        step(32'd1 << 7, 1'b0);
        step(32'd1 << 7, 1'b0);
        chk("l7_valid", 32'(vld), 32'd1);
        chk("l7_data", 32'(data), 32'd7);
        step(32'd1 << 7, 1'b1);
        chk("l7_grant_pulse_lost", lost, 32'd0);
        chk("l7_grant_pulse_valid", 32'(vld), 32'd1);
        xfers = 0;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (vld) begin
                xfers++;
                if (data !== 8'd7) stable = 1'b0;
            end
            step(32'd0, 1'b1);
        end
        chk("l7_drain_count", 32'(xfers), 32'd4);
        chk("l7_drain_id", 32'(stable), 32'd1);
        chk("l7_idle_busy", 32'(busy), 32'd0);

`ifdef SOC_EVT_LOST_CNT_EN
        do_reset();
        chk("lc_reset", 32'(lost_cnt), 32'd0);
        step(32'h3, 1'b0);
        step(32'h3, 1'b0);
        chk("lc_first_grant", 32'(data), 32'd1);
        step(32'h3, 1'b0);
        step(32'h3, 1'b0);
        chk("lc_lost_l0", lost, 32'h1);
        chk("lc_before", 32'(lost_cnt), 32'd0);
        step(32'h3, 1'b0);
        chk("lc_lost_both", lost, 32'h3);
        chk("lc_one", 32'(lost_cnt), 32'd1);
        step(32'h3, 1'b0);
        chk("lc_plus_two", 32'(lost_cnt), 32'd3);
        step(32'h1, 1'b0);
        chk("lc_plus_two_again", 32'(lost_cnt), 32'd5);
        chk("lc_single_loss", lost, 32'h1);
        lost_clr = 1'b1;
        step(32'h0, 1'b0);
        lost_clr = 1'b0;
        chk("lc_clr_with_loss", 32'(lost_cnt), 32'd1);
        step(32'h0, 1'b0);
        chk("lc_hold", 32'(lost_cnt), 32'd1);
`endif

        // Asynchronous reset while a transfer is pending.
        step(32'd1 << 9, 1'b0);
        step(32'd1 << 9, 1'b0);
        chk("rst_pre_valid", 32'(vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(vld),  32'd0);
        chk("rst_async_data",  32'(data), 32'd0);
        chk("rst_async_lost",  lost,      32'd0);
        chk("rst_async_busy",  32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            step(32'd0, 1'b1);
            if (vld) xfers++;
        end
        chk("rst_no_replay", 32'(xfers), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
